display_scan_ctrl: RTL and testbench

//  Scan scheduler for the 4-digit multiplexed 7-segment display.
//  - Time-shares one segment bus between digits; holds a frame-coherent shadow copy of BCD/DP data.
//  - Inserts dead-time blanking between digits to prevent ghosting.
//  - Applies leading-zero blanking and 3-bit PWM brightness.
//  - Sits between the BCD counter/splitter logic and the board segment/anode pins.

---
 rtl/display_scan_ctrl_pkg.sv | 23 ++
 rtl/display_scan_ctrl_if.sv | 23 ++
 rtl/display_scan_ctrl_seg7_decode.sv | 19 +
 rtl/display_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared types, constants and sizing helpers for the 4-digit display scan scheduler.
package disp_pkg;

    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [7:0] SEG_DASH = 8'hBF;

    // Active-low {dp,g,f,e,d,c,b,a}; dp bit left off, merged in by the decoder.
    localparam logic [7:0] GLYPH [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    typedef enum logic [1:0] {IDLE, BLANK, LIT, DARK} scan_st_t;

    function automatic int calc_div(input int clk_hz, input int scan_hz);
        return clk_hz / scan_hz;
    endfunction

    function automatic int calc_on_len(input int div, input int blank_cyc, input logic [2:0] bright);
        return ((div - blank_cyc) * (int'(bright) + 1)) >> 3;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Data/control bundle between the BCD source logic and the display scan scheduler.
interface display_scan_ctrl_if;
    logic        en;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        upd;
    logic        lzb_en;
    logic [2:0]  bright;
    logic [7:0]  segmentos;
    logic [3:0]  sel_seg;
    logic [1:0]  cur_dig;
    logic        frame_done;

    modport master (
        output en, bcd_in, dp_in, upd, lzb_en, bright,
        input  segmentos, sel_seg, cur_dig, frame_done
    );

    modport slave (
        input  en, bcd_in, dp_in, upd, lzb_en, bright,
        output segmentos, sel_seg, cur_dig, frame_done
    );
endinterface

// File: rtl/display_scan_ctrl_seg7_decode.sv
// Combinational BCD nibble + decimal point to active-low 7-segment code.
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);
    always_comb begin
        seg = SEG_DASH;
        if (blank)
            seg = SEG_OFF;
        else if (nib <= 4'd9)
            seg = GLYPH[nib];
        // A leading-zero-blanked digit still shows its decimal point.
        seg[7] = ~dp;
    end
endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan scheduler with dead-time blanking, LZB and PWM brightness.
//  state | meaning
//  IDLE  | scan stopped, pins dark, counters cleared
//  BLANK | first BLANK_CYC cycles of a slot, anodes off to avoid ghosting
//  LIT   | current digit driven for on_len cycles
//  DARK  | remainder of the slot after the PWM on-time, pins dark
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SCAN_HZ   = 1000,
    parameter int BLANK_CYC = 500
) (
    input logic                clk,
    input logic                rst,
    display_scan_ctrl_if.slave bus
);
    localparam int DIV = calc_div(CLK_HZ, SCAN_HZ);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_PRE    = CW'(DIV - 2);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    scan_st_t    st;
    logic [CW-1:0] cnt;
    logic [CW-1:0] lit_end;
    logic [1:0]  dig;
    logic [15:0] shadow_bcd, pend_bcd;
    logic [3:0]  shadow_dp, pend_dp;
    logic        pend_v;
    logic [7:0]  seg_q;
    logic [3:0]  sel_q;
    logic        fd_q;

    logic [3:0]  zero;
    logic [3:0]  lead_zero;
    logic [3:0]  nib;
    logic        lz_blank;
    logic [7:0]  glyph;

    assign zero = {shadow_bcd[15:12] == 4'd0, shadow_bcd[11:8] == 4'd0,
                   shadow_bcd[7:4] == 4'd0,   shadow_bcd[3:0] == 4'd0};
    assign lead_zero = {zero[3], zero[3] & zero[2], zero[3] & zero[2] & zero[1], 1'b0};
    assign nib       = shadow_bcd[{dig, 2'b00} +: 4];
    assign lz_blank  = bus.lzb_en & lead_zero[dig];

    seg7_decode u_dec (
        .nib   (nib),
        .dp    (shadow_dp[dig]),
        .blank (lz_blank),
        .seg   (glyph)
    );

    assign bus.segmentos  = seg_q;
    assign bus.sel_seg    = sel_q;
    assign bus.cur_dig    = dig;
    assign bus.frame_done = fd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= IDLE;
            cnt        <= '0;
            lit_end    <= '0;
            dig        <= 2'd0;
            shadow_bcd <= '0;
            shadow_dp  <= '0;
            pend_bcd   <= '0;
            pend_dp    <= '0;
            pend_v     <= 1'b0;
            seg_q      <= SEG_OFF;
            sel_q      <= 4'hF;
            fd_q       <= 1'b0;
        end else begin
            // Shadow only changes at a frame boundary (or while stopped) so a frame is coherent.
            if (bus.upd) begin
                if (st == IDLE || fd_q) begin
                    shadow_bcd <= bus.bcd_in;
                    shadow_dp  <= bus.dp_in;
                    pend_v     <= 1'b0;
                end else begin
                    pend_bcd <= bus.bcd_in;
                    pend_dp  <= bus.dp_in;
                    pend_v   <= 1'b1;
                end
            end else if (fd_q && pend_v) begin
                shadow_bcd <= pend_bcd;
                shadow_dp  <= pend_dp;
                pend_v     <= 1'b0;
            end

            seg_q <= (st == LIT) ? glyph : SEG_OFF;
            sel_q <= (st == LIT) ? ~(4'b0001 << dig) : 4'hF;
            fd_q  <= 1'b0;

            if (!bus.en) begin
                st  <= IDLE;
                cnt <= '0;
                dig <= 2'd0;
            end else begin
                if (st != IDLE) begin
                    fd_q <= (dig == 2'd3) && (cnt == CNT_PRE);
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        dig <= dig + 2'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                if (st == BLANK && cnt == '0)
                    lit_end <= CW'(BLANK_CYC + calc_on_len(DIV, BLANK_CYC, bus.bright) - 1);
                case (st)
                    IDLE: begin
                        st  <= BLANK;
                        cnt <= '0;
                        dig <= 2'd0;
                    end
                    BLANK: if (cnt == BLANK_LAST) st <= LIT;
                    LIT: begin
                        if (cnt == CNT_LAST)
                            st <= BLANK;
                        else if (cnt == lit_end)
                            st <= DARK;
                    end
                    DARK: if (cnt == CNT_LAST) st <= BLANK;
                    default: st <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with DIV=10, BLANK_CYC=2 (40-cycle frames).
module tb_display_scan_ctrl;
    localparam int DIV_T = 10;
    localparam int BLK_T = 2;
    localparam int NOSW  = 1_000_000;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] sel;
        logic       fd;
        logic [1:0] dig;
    } exp_t;

    typedef struct {
        logic [15:0]     bcd;
        logic [3:0]      dp;
        logic            lzb;
        logic [2:0]      br;
        int              ol;
        logic [3:0][7:0] segs;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    vec_t vecs[9];

    localparam logic [3:0][7:0] S1234 = {8'hF9, 8'hA4, 8'hB0, 8'h99};
    localparam logic [3:0][7:0] S5678 = {8'h92, 8'h82, 8'hF8, 8'h80};
    localparam logic [3:0][7:0] S4321 = {8'h99, 8'hB0, 8'hA4, 8'hF9};
    localparam logic [3:0][7:0] S0000 = {8'hC0, 8'hC0, 8'hC0, 8'hC0};

    display_scan_ctrl_if bus();

    display_scan_ctrl #(.CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYC(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] seg, input logic [3:0] sel, input logic fd, input logic [1:0] dig);
        exp_t e;
        e.seg = seg;
        e.sel = sel;
        e.fd  = fd;
        e.dig = dig;
        sb_q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        exp_t a;
        a = {bus.segmentos, bus.sel_seg, bus.frame_done, bus.cur_dig};
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no expected entry queued, got seg=%h sel=%b", tag, a.seg, a.sel);
        end else begin
            e = sb_q.pop_front();
            if (a !== e) begin
                errors++;
                $display("FAIL %s @%0t: got seg=%h sel=%b fd=%b dig=%0d want seg=%h sel=%b fd=%b dig=%0d",
                         tag, $time, a.seg, a.sel, a.fd, a.dig, e.seg, e.sel, e.fd, e.dig);
            end
        end
    endtask

    // r counts edges after the enabling edge; pins at r show the scan state of cycle r-1.
    task automatic frame_run(input string tag, input int r0, input int r1,
                             input logic [3:0][7:0] sa, input logic [3:0][7:0] sb, input int sw,
                             input int ola, input int olb, input int olsw);
        int s, pos, d, ol;
        logic [3:0][7:0] sg;
        logic [7:0] seg;
        logic [3:0] sel;
        for (int r = r0; r <= r1; r++) begin
            s   = r - 1;
            pos = s % DIV_T;
            d   = (s / DIV_T) % 4;
            sg  = (s >= sw) ? sb : sa;
            ol  = (s >= olsw) ? olb : ola;
            seg = 8'hFF;
            sel = 4'hF;
            if (pos >= BLK_T && pos < BLK_T + ol) begin
                seg = sg[d];
                sel = ~(4'b0001 << d);
            end
            push_exp(seg, sel, (r % 40) == 39, 2'((r / DIV_T) % 4));
            tick();
            check_out(tag);
        end
    endtask

    task automatic load_idle(input logic [15:0] bcd, input logic [3:0] dp);
        bus.en = 1'b0;
        tick();
        bus.bcd_in = bcd;
        bus.dp_in  = dp;
        bus.upd    = 1'b1;
        tick();
        bus.upd = 1'b0;
    endtask

    task automatic enable_run(input string tag);
        bus.en = 1'b1;
        push_exp(8'hFF, 4'hF, 1'b0, 2'd0);
        tick();
        check_out(tag);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 1'b0, 3'd7, 8, S1234};
        vecs[1] = '{16'h1234, 4'b0000, 1'b0, 3'd0, 1, S1234};
        vecs[2] = '{16'h1234, 4'b0000, 1'b0, 3'd3, 4, S1234};
        vecs[3] = '{16'h0007, 4'b0000, 1'b1, 3'd7, 8, {8'hFF, 8'hFF, 8'hFF, 8'hF8}};
        vecs[4] = '{16'h0007, 4'b0000, 1'b0, 3'd7, 8, {8'hC0, 8'hC0, 8'hC0, 8'hF8}};
        vecs[5] = '{16'h000C, 4'b0000, 1'b1, 3'd7, 8, {8'hFF, 8'hFF, 8'hFF, 8'hBF}};
        vecs[6] = '{16'h0007, 4'b0010, 1'b1, 3'd7, 8, {8'hFF, 8'hFF, 8'h7F, 8'hF8}};
        vecs[7] = '{16'h9A05, 4'b1001, 1'b1, 3'd5, 6, {8'h10, 8'hBF, 8'hC0, 8'h12}};
        vecs[8] = '{16'h0080, 4'b0000, 1'b1, 3'd1, 2, {8'hFF, 8'hFF, 8'h80, 8'hC0}};

        rst        = 1'b1;
        bus.en     = 1'b0;
        bus.bcd_in = '0;
        bus.dp_in  = '0;
        bus.upd    = 1'b0;
        bus.lzb_en = 1'b0;
        bus.bright = 3'd0;
        repeat (3) tick();
        push_exp(8'hFF, 4'hF, 1'b0, 2'd0);
        check_out("reset");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            push_exp(8'hFF, 4'hF, 1'b0, 2'd0);
            tick();
            check_out("idle_hold");
        end

        foreach (vecs[i]) begin
            load_idle(vecs[i].bcd, vecs[i].dp);
            bus.lzb_en = vecs[i].lzb;
            bus.bright = vecs[i].br;
            enable_run("vec_start");
            frame_run($sformatf("vec%0d", i), 1, 41, vecs[i].segs, vecs[i].segs, NOSW,
                      vecs[i].ol, vecs[i].ol, NOSW);
        end

        // Brightness change mid-slot only affects the following slot.
        load_idle(16'h1234, 4'b0000);
        bus.lzb_en = 1'b0;
        bus.bright = 3'd3;
        enable_run("bright_start");
        frame_run("bright_pre", 1, 5, S1234, S1234, NOSW, 4, 1, 10);
        bus.bright = 3'd0;
        frame_run("bright_chg", 6, 25, S1234, S1234, NOSW, 4, 1, 10);

        // Mid-frame update waits for the frame boundary; an update on the boundary wins over pending data.
        load_idle(16'h1234, 4'b0000);
        bus.bright = 3'd7;
        enable_run("upd_start");
        frame_run("upd_a", 1, 15, S1234, S5678, 40, 8, 8, NOSW);
        bus.bcd_in = 16'h5678;
        bus.upd    = 1'b1;
        frame_run("upd_b", 16, 16, S1234, S5678, 40, 8, 8, NOSW);
        bus.upd = 1'b0;
        frame_run("upd_c", 17, 60, S1234, S5678, 40, 8, 8, NOSW);
        bus.bcd_in = 16'h1111;
        bus.upd    = 1'b1;
        frame_run("upd_d", 61, 61, S1234, S5678, 40, 8, 8, NOSW);
        bus.upd = 1'b0;
        frame_run("upd_e", 62, 79, S1234, S5678, 40, 8, 8, NOSW);
        bus.bcd_in = 16'h4321;
        bus.upd    = 1'b1;
        frame_run("upd_f", 80, 80, S5678, S4321, 80, 8, 8, NOSW);
        bus.upd = 1'b0;
        frame_run("upd_g", 81, 121, S5678, S4321, 80, 8, 8, NOSW);

        // Disable while digit2 is lit, then restart from digit0.
        load_idle(16'h1234, 4'b0000);
        enable_run("stop_start");
        frame_run("stop_run", 1, 25, S1234, S1234, NOSW, 8, 8, NOSW);
        bus.en = 1'b0;
        push_exp(8'hA4, 4'b1011, 1'b0, 2'd0);
        tick();
        check_out("stop_lag");
        push_exp(8'hFF, 4'hF, 1'b0, 2'd0);
        tick();
        check_out("stop_dark");
        enable_run("stop_restart");
        frame_run("stop_rerun", 1, 12, S1234, S1234, NOSW, 8, 8, NOSW);

        // Synchronous reset while lit also clears the shadow data.
        bus.en = 1'b0;
        tick();
        enable_run("rst_start");
        frame_run("rst_run", 1, 25, S1234, S1234, NOSW, 8, 8, NOSW);
        rst = 1'b1;
        push_exp(8'hFF, 4'hF, 1'b0, 2'd0);
        tick();
        check_out("rst_mid");
        rst = 1'b0;
        push_exp(8'hFF, 4'hF, 1'b0, 2'd0);
        tick();
        check_out("rst_restart");
        frame_run("rst_rerun", 1, 41, S0000, S0000, NOSW, 8, 8, NOSW);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
